seq_chain_counter: RTL

Parametrised multi-channel sequential counter engine for generated top-level designs. It runs a fixed program of CHANNELS counters one at a time: each channel counts from 0 up to a limit, then control passes to the next channel. Over the single-program top it adds configurable width, channel count and limit, a start/busy/done handshake, loop mode, abort, and a pass counter. It sits directly under the top module and drives the observable result registers.

---
 rtl/seq_chain_counter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_chain_counter.sv
// Multi-channel sequential counter engine: channels count 0..limit one after another,
// with start/busy/done handshake, loop mode, abort and a wrapping pass counter.
module seq_chain_counter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          limit,
  input  logic                      loop,
  input  logic                      abort,
  output logic [CHANNELS*WIDTH-1:0] cnt,
  output logic [CH_W-1:0]           ch_idx,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          passes
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic [WIDTH-1:0] cnt_d [CHANNELS];
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
  logic [WIDTH-1:0] passes_q, passes_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             loop_q, loop_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] act_cnt;
  logic             at_lim, last_ch, accept, run_step, final_edge;

  // Value of the channel currently selected by ch_idx_q
  always_comb begin
    act_cnt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_idx_q == CH_W'(k)) act_cnt = cnt_q[k];
    end
  end

  assign at_lim     = (act_cnt == lim_q);
  assign last_ch    = (ch_idx_q == CH_W'(CHANNELS - 1));
  assign accept     = (state_q == S_IDLE) && start && !abort;
  assign run_step   = (state_q == S_RUN) && !abort;
  assign final_edge = run_step && at_lim && last_ch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN:  if (abort || (final_edge && !loop_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: abort simply freezes everything since no step is taken
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) cnt_d[k] = cnt_q[k];
    ch_idx_d = ch_idx_q;
    passes_d = passes_q;
    lim_d    = lim_q;
    loop_d   = loop_q;
    done_d   = 1'b0;
    if (accept) begin
      lim_d    = limit;
      loop_d   = loop;
      for (int k = 0; k < CHANNELS; k++) cnt_d[k] = '0;
      ch_idx_d = '0;
      passes_d = '0;
    end else if (run_step) begin
      if (!at_lim) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (ch_idx_q == CH_W'(k)) cnt_d[k] = cnt_q[k] + WIDTH'(1);
        end
      end else if (!last_ch) begin
        ch_idx_d = ch_idx_q + CH_W'(1);
      end else begin
        done_d   = 1'b1;
        passes_d = passes_q + WIDTH'(1);
        if (loop_q) begin
          for (int k = 0; k < CHANNELS; k++) cnt_d[k] = '0;
          ch_idx_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= '0;
      ch_idx_q <= '0;
      passes_q <= '0;
      lim_q    <= '0;
      loop_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) cnt_q[k] <= cnt_d[k];
      ch_idx_q <= ch_idx_d;
      passes_q <= passes_d;
      lim_q    <= lim_d;
      loop_q   <= loop_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < CHANNELS; k++) cnt[k*WIDTH +: WIDTH] = cnt_q[k];
    ch_idx = ch_idx_q;
    busy   = (state_q == S_RUN);
    done   = done_q;
    passes = passes_q;
  end

endmodule
